alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Multi-cycle 32-bit ALU that consumes the 4-bit ALU control code produced by the CPU's ALU controller and executes it.
- Single-cycle operations complete in one clock; multiply runs an iterative shift-add loop.
- A start/ready/valid handshake lets the datapath stall around the multiply.
- Sits in the execute stage, between the register-file/immediate muxes and the writeback mux.

Parameters:
WIDTH, 32, operand/result width; multiply iteration count equals WIDTH
CW, 6, width of multiply iteration counter (must satisfy 2^CW > WIDTH)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
start_i  input  1  operation request; accepted only when ready_o=1
ctrl_i  input  4  ALU control code
src1_i  input  WIDTH  operand 1 (rs); low 5 bits = variable shift amount
src2_i  input  WIDTH  operand 2 (rt/imm)
shamt_i  input  5  constant shift amount for sra
ready_o  output  1  1 = idle, can accept start_i
valid_o  output  1  one-cycle pulse: result_o/zero_o/overflow_o are new
result_o  output  WIDTH  registered result
zero_o  output  1  registered (result==0)
overflow_o  output  1  registered signed overflow (add/sub only, else 0)

Behaviour:
- Clock clk_i; reset rst_i is asynchronous, active-low. The interface is fully synchronous to clk_i.
- Reset values: state=IDLE, ready_o=1, valid_o=0, result_o=0, zero_o=1, overflow_o=0, counter=0, internal product/multiplicand regs=0.
- Control codes:
  - 0000 AND
  - 0001 OR
  - 0010 add
  - 0110 sub (src1-src2)
  - 0111 slt signed (1/0)
  - 0011 sle signed (src1<=src2 → 1)
  - 1000 sra: src2 >>> shamt_i
  - 1001 srav: src2 >>> src1[4:0]
  - 1100 mul: low WIDTH bits of src1*src2
  - any other code: result 0, overflow 0.
- Overflow for add/sub: set when operand signs make the result sign wrong (add: equal-sign operands, result sign differs; sub: differing-sign operands, result sign differs from src1).
- States: IDLE, MUL, DONE.
- IDLE:
  - ready_o=1.
  - start_i=1 with a non-mul code: compute combinationally, register result/zero/overflow → DONE.
  - start_i=1 with code 1100: latch multiplicand=src1, multiplier=src2, accumulator=0, counter=0 → MUL.
  - start_i=0: stay in IDLE.
- MUL:
  - ready_o=0.
  - Each cycle: if multiplier[0], accumulator += multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1; counter++.
  - After WIDTH iterations (counter==WIDTH-1 on the update edge): register result=accumulator final value, zero accordingly, overflow=0 → DONE.
  - No early termination.
- DONE:
  - valid_o=1 for exactly this cycle; ready_o=0 → IDLE.
  - start_i in DONE is ignored.
- Latency, with the accept edge at cycle 0:
  - single-cycle op: valid_o high in cycle 1; next accept possible at cycle 2.
  - mul: valid_o high in cycle WIDTH+1 (33 at default).
- result_o/zero_o/overflow_o hold their value after DONE until the next completion.
- start_i while ready_o=0 is ignored and not queued.
- Operands and ctrl_i are sampled only on the accept edge. Later input changes have no effect on an in-flight mul.
- Reset asserted mid-operation: immediate return to reset values; the in-flight op is lost and no valid_o is produced.

Decomposition:
- Shared package `alu_pkg` holds:
  - the 4-bit control code constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLE, ALU_SRA, ALU_SRAV, ALU_MUL.
  - the state encoding.
- The ALU controller imports the same package so both ends agree on the codes.
- One natural sub-module, `alu_comb`: purely combinational single-cycle datapath covering all non-mul codes, with outputs result/overflow.
- The FSM and multiply loop stay in `alu_seq`.

Test Plan:
- Reset then add: start, ctrl=0010, src1=0x7FFFFFFF, src2=1 → cycle 1: valid_o=1, result=0x80000000, overflow_o=1, zero_o=0; cycle 2: ready_o=1.
- Sub zero: ctrl=0110, src1=src2=0x12345678 → result=0, zero_o=1, overflow_o=0. Then slt with src1=0xFFFFFFFF, src2=1 → result=1; sle with src1=src2=5 → result=1.
- Shifts:
  - sra: src2=0x80000000, shamt_i=4 → 0xF8000000.
  - srav: src1=31, src2=0x80000000 → 0xFFFFFFFF.
  - undefined code 1111 → result 0.
- Mul: src1=0xFFFFFFFD (-3), src2=7 → ready_o=0 in cycles 1..32, valid_o only in cycle 33, result=0xFFFFFFEB, zero_o=0. Holding start_i=1 with changed operands during MUL → no effect, single valid pulse.
- Reset mid-mul: drive rst_i low at cycle 10 of a mul → ready_o=1, valid_o=0, result_o=0 immediately; no valid_o pulse afterwards. Then a new add 2+3 → result 5 at cycle 1.
- Back-to-back: start held high continuously with add ops → accepted every 2 cycles, one valid_o pulse per accept, results in order.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and sequencer state encoding shared by the ALU and its controller.
// Revision 1.0
`default_nettype none

package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLE  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SRAV = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_comb.sv
// alu_comb: single-cycle ALU datapath for every non-multiply control code.
// Revision 1.0
`default_nettype none

module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt;
  logic             eq;

  assign sum  = src1 + src2;
  assign diff = src1 - src2;
  assign lt   = ($signed(src1) < $signed(src2));
  assign eq   = (src1 == src2);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (ctrl)
      ALU_AND:  result = src1 & src2;
      ALU_OR:   result = src1 | src2;
      ALU_ADD: begin
        result   = sum;
        overflow = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);
      end
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt};
      ALU_SLE:  result = {{(WIDTH-1){1'b0}}, lt | eq};
      ALU_SRA:  result = $signed(src2) >>> shamt;
      ALU_SRAV: result = $signed(src2) >>> src1[4:0];
      // Multiply is handled by the sequencer; unknown codes yield zero.
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/ready/valid handshake and WIDTH-iteration shift-add multiply.
// Revision 1.0
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [4:0]       shamt_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o
);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             mul_last;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_step;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] comb_result;
  logic             comb_overflow;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .ctrl     (ctrl_i),
    .src1     (src1_i),
    .src2     (src2_i),
    .shamt    (shamt_i),
    .result   (comb_result),
    .overflow (comb_overflow)
  );

  assign acc_step = mplier[0] ? (acc + mcand) : acc;
  assign mul_last = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          accept    = 1'b1;
          state_nxt = (ctrl_i == ALU_MUL) ? ST_MUL : ST_DONE;
        end
      end
      ST_MUL: begin
        if (mul_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        valid_o   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result registers only change on a completion; they hold between operations.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      result_o   <= '0;
      zero_o     <= 1'b1;
      overflow_o <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      count      <= '0;
    end else if (accept) begin
      if (ctrl_i == ALU_MUL) begin
        mcand  <= src1_i;
        mplier <= src2_i;
        acc    <= '0;
        count  <= '0;
      end else begin
        result_o   <= comb_result;
        zero_o     <= (comb_result == '0);
        overflow_o <= comb_overflow;
      end
    end else if (state == ST_MUL) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (mul_last) begin
        result_o   <= acc_step;
        zero_o     <= (acc_step == '0);
        overflow_o <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven, hand-sequenced and randomized checks of alu_seq against a reference model.
// Revision 1.0
`default_nettype none

module tb_alu_seq;

  localparam int WIDTH = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -MAXS - 64'sd1;

  logic        clk_i   = 1'b0;
  logic        rst_i   = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  ctrl_i  = 4'd0;
  logic [31:0] src1_i  = 32'd0;
  logic [31:0] src2_i  = 32'd0;
  logic [4:0]  shamt_i = 5'd0;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic        zero_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(WIDTH), .CW(6)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .ctrl_i     (ctrl_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .shamt_i    (shamt_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .zero_o     (zero_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operand values.
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] r, output logic ov);
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    r  = 32'd0;
    ov = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin s = sa + sb; r = s[31:0]; ov = (s > MAXS) || (s < MINS); end
      4'b0110: begin s = sa - sb; r = s[31:0]; ov = (s > MAXS) || (s < MINS); end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b0011: r = (sa <= sb) ? 32'd1 : 32'd0;
      4'b1000: begin s = sb >>> sh; r = s[31:0]; end
      4'b1001: begin s = sb >>> a[4:0]; r = s[31:0]; end
      4'b1100: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      default: r = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFFFFFF;
      1:       return 32'h80000000;
      2:       return 32'h00000000;
      3:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from IDLE and check latency, busy behaviour, outputs and the return to IDLE.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] exp_r, input logic exp_z,
                        input logic exp_ov, input bit hold, input string tag);
    int cyc;
    int busy_bad;
    int lat;
    lat = (c == 4'b1100) ? WIDTH : 0;
    @(negedge clk_i);
    chk($sformatf("%s_ready_pre", tag), ready_o, 1);
    start_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b; shamt_i = sh;
    @(posedge clk_i); #1;
    if (!hold) start_i = 1'b0;
    cyc = 0;
    busy_bad = 0;
    while (!valid_o && cyc < 60) begin
      if (ready_o) busy_bad++;
      if (hold) begin
        src1_i = $urandom; src2_i = $urandom; ctrl_i = 4'($urandom); shamt_i = 5'($urandom);
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    chk($sformatf("%s_latency", tag), cyc, lat);
    chk($sformatf("%s_busy_ready", tag), busy_bad, 0);
    chk($sformatf("%s_result", tag), result_o, exp_r);
    chk($sformatf("%s_zero", tag), zero_o, exp_z);
    chk($sformatf("%s_overflow", tag), overflow_o, exp_ov);
    start_i = 1'b0;
    @(posedge clk_i); #1;
    chk($sformatf("%s_valid_drop", tag), valid_o, 0);
    chk($sformatf("%s_ready_post", tag), ready_o, 1);
    chk($sformatf("%s_result_hold", tag), result_o, exp_r);
  endtask

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        zero;
    logic        ov;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int vcount;
    int nvalid;
    int acc_cyc[$];
    logic [31:0] expq[$];

    vecs[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b1};
    vecs[1]  = '{4'b0110, 32'h12345678, 32'h12345678, 5'd0, 32'h00000000, 1'b1, 1'b0};
    vecs[2]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0};
    vecs[3]  = '{4'b0011, 32'h00000005, 32'h00000005, 5'd0, 32'h00000001, 1'b0, 1'b0};
    vecs[4]  = '{4'b1000, 32'h00000000, 32'h80000000, 5'd4, 32'hF8000000, 1'b0, 1'b0};
    vecs[5]  = '{4'b1001, 32'h0000001F, 32'h80000000, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[6]  = '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000000, 1'b1, 1'b0};
    vecs[7]  = '{4'b1100, 32'hFFFFFFFD, 32'h00000007, 5'd0, 32'hFFFFFFEB, 1'b0, 1'b0};
    vecs[8]  = '{4'b0110, 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[9]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0, 1'b0};
    vecs[10] = '{4'b0001, 32'h0F000000, 32'h000000F0, 5'd0, 32'h0F0000F0, 1'b0, 1'b0};
    vecs[11] = '{4'b0111, 32'h00000001, 32'hFFFFFFFF, 5'd0, 32'h00000000, 1'b1, 1'b0};
    vecs[12] = '{4'b0011, 32'h00000006, 32'h00000005, 5'd0, 32'h00000000, 1'b1, 1'b0};
    vecs[13] = '{4'b1100, 32'h00010000, 32'h00010000, 5'd0, 32'h00000000, 1'b1, 1'b0};

    // Reset state
    #23;
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_zero", zero_o, 1);
    chk("rst_overflow", overflow_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].res, vecs[i].zero,
             vecs[i].ov, 1'b0, $sformatf("vec%0d", i));

    // Operand changes while start stays high during a multiply must not disturb it.
    run_op(4'b1100, 32'hFFFFFFFD, 32'h00000007, 5'd0, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b1, "mul_hold");

    // Reset in the middle of a multiply.
    run_op(4'b0010, 32'd7, 32'd8, 5'd0, 32'd15, 1'b0, 1'b0, 1'b0, "pre_rst_add");
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = 4'b1100; src1_i = 32'd3; src2_i = 32'd5;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("midrst_ready", ready_o, 1);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_zero", zero_o, 1);
    @(negedge clk_i);
    rst_i = 1'b1;
    vcount = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (valid_o) vcount++;
    end
    chk("midrst_no_valid", vcount, 0);
    run_op(4'b0010, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0, 1'b0, "post_rst_add");

    // Back-to-back adds with start held high: one accept every two cycles.
    nvalid = 0;
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = 4'b0010;
    for (int t = 0; t < 12; t++) begin
      src1_i = 32'(t * 100 + 1);
      src2_i = 32'(t * 7 + 3);
      if (ready_o) begin
        expq.push_back(32'(t * 107 + 4));
        acc_cyc.push_back(t);
      end
      @(posedge clk_i); #1;
      if (valid_o) begin
        nvalid++;
        if (expq.size() > 0) chk("b2b_result", result_o, expq.pop_front());
        else chk("b2b_spurious_valid", 1, 0);
      end
      @(negedge clk_i);
    end
    start_i = 1'b0;
    chk("b2b_accepts", acc_cyc.size(), 6);
    chk("b2b_valids", nvalid, 6);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 2);
    @(posedge clk_i); #1;

    // Randomized operations against the reference model.
    for (int i = 0; i < 120; i++) begin
      logic [3:0]  c;
      logic [31:0] a, b, r;
      logic [4:0]  sh;
      logic        ov;
      c  = 4'($urandom_range(0, 15));
      a  = pick();
      b  = pick();
      sh = 5'($urandom);
      model(c, a, b, sh, r, ov);
      run_op(c, a, b, sh, r, (r == 32'd0), ov, ($urandom_range(0, 1) == 1),
             $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
